// File: rtl/sr_stream_fifo_pkg.sv
// Shared defaults and transfer classification for the stream FIFO.
// The SR_FIFO_BYPASS_EN macro, used by sr_stream_fifo, enables empty-FIFO fall-through.
package sr_stream_fifo_pkg;

  localparam int unsigned SR_FIFO_DEPTH_DEFAULT = 8;
  localparam int unsigned SR_FIFO_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    XFER_IDLE = 2'b00,
    XFER_PUSH = 2'b01,
    XFER_POP  = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

  function automatic xfer_e xfer_kind(input logic push, input logic pop);
    return xfer_e'({pop, push});
  endfunction

endpackage

// File: rtl/sr_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module sr_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sr_stream_fifo.sv
// First-word-fall-through FIFO behind the CPU push/pop port; head word is combinational.
// Define SR_FIFO_BYPASS_EN to let a push+pop on an empty FIFO pass writeData straight through.
module sr_stream_fifo
  import sr_stream_fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = SR_FIFO_WIDTH_DEFAULT,
  parameter  int unsigned DEPTH      = SR_FIFO_DEPTH_DEFAULT,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  writeEnable,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  readEnable,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  errClear
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] FULL_XOR = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  empty_w, full_w, bypass_w;
  logic                  push_ok, pop_ok;
  logic                  overflow_set, underflow_set;
  logic [DATA_WIDTH-1:0] mem_rdata;

  always_comb begin
    empty_w = (wr_ptr_q == rd_ptr_q);
    full_w  = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
`ifdef SR_FIFO_BYPASS_EN
    bypass_w = empty_w && writeEnable && readEnable;
`else
    bypass_w = 1'b0;
`endif
  end

  // In bypass both pointers advance: the word is written and consumed in the same edge.
  always_comb begin
    push_ok       = writeEnable && (!full_w || readEnable);
    pop_ok        = readEnable && (!empty_w || bypass_w);
    overflow_set  = writeEnable && full_w && !readEnable;
    underflow_set = readEnable && empty_w && !bypass_w;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    unique case (xfer_kind(push_ok, pop_ok))
      XFER_PUSH: wr_ptr_d = wr_ptr_q + PTR_ONE;
      XFER_POP:  rd_ptr_d = rd_ptr_q + PTR_ONE;
      XFER_BOTH: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      default: ;
    endcase

    overflow_d  = overflow_set  || (overflow_q  && !errClear);
    underflow_d = underflow_set || (underflow_q && !errClear);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sr_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (writeData),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  always_comb begin
    if (bypass_w) begin
      readData = writeData;
    end else if (empty_w) begin
      readData = '0;
    end else begin
      readData = mem_rdata;
    end
  end

  assign full      = full_w;
  assign empty     = empty_w;
  assign count     = wr_ptr_q - rd_ptr_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
